// File: rtl/ray_gen_normalizer.sv
// Normalizes a signed Q16.16 direction vector to unit length with a bit-serial sqrt and dividers.
// Optional RAY_GEN_ZERO_GUARD_EN forces a zero vector to a zero result instead of 0x0001_FFFF.
module ray_gen_normalizer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ray_gen_start,
  input  logic [31:0] ray_gen_in_x,
  input  logic [31:0] ray_gen_in_y,
  input  logic [31:0] ray_gen_in_z,
  output logic        ray_gen_done,
  output logic [31:0] ray_gen_out_x,
  output logic [31:0] ray_gen_out_y,
  output logic [31:0] ray_gen_out_z
);

  typedef enum logic [2:0] {StIdle, StSquare, StSqrt, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q;
  logic [2:0][31:0] vec_q;
  logic [2:0][31:0] mag_q;
  logic [2:0]       sign_q;
  logic [63:0]      rad_q;
  logic [32:0]      srem_q;
  logic [31:0]      root_q;
  logic [2:0][31:0] drem_q;
  logic [2:0][15:0] quo_q;
  logic [2:0][31:0] out_q;
  logic             zero_guard;

  // Square stage: magnitudes and their sum of squares
  logic [2:0][31:0] mag_c;
  logic [63:0]      rad_c;

  always_comb begin
    rad_c = '0;
    for (int i = 0; i < 3; i++) begin
      mag_c[i] = vec_q[i][31] ? (~vec_q[i] + 32'd1) : vec_q[i];
      rad_c    = rad_c + 64'(mag_c[i]) * 64'(mag_c[i]);
    end
  end

  // One digit-recurrence root step: bring down two radicand bits, try (4*root + 1)
  logic [34:0] s_acc, s_trial;
  logic        s_ge;
  logic [32:0] srem_d;

  always_comb begin
    s_acc   = {srem_q, rad_q[63:62]};
    s_trial = {1'b0, root_q, 2'b01};
    s_ge    = (s_acc >= s_trial);
    srem_d  = s_ge ? 33'(s_acc - s_trial) : s_acc[32:0];
  end

  // Restoring divide step; dividend is |in| << 16, so only bit 16 of the low part can be set
  logic [2:0][32:0] d_acc;
  logic [2:0]       d_ge;
  logic [2:0][31:0] drem_d;
  logic [2:0][16:0] q_fin;
  logic [2:0][31:0] q_ext;
  logic [2:0][31:0] out_d;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      d_acc[i]  = {drem_q[i], (cnt_q == 5'd16) ? mag_q[i][0] : 1'b0};
      d_ge[i]   = (d_acc[i] >= {1'b0, root_q});
      drem_d[i] = d_ge[i] ? 32'(d_acc[i] - {1'b0, root_q}) : d_acc[i][31:0];
      q_fin[i]  = {quo_q[i], d_ge[i]};
      q_ext[i]  = {15'b0, q_fin[i]};
      if (zero_guard) begin
        out_d[i] = '0;
      end else begin
        out_d[i] = sign_q[i] ? (~q_ext[i] + 32'd1) : q_ext[i];
      end
    end
  end

`ifdef RAY_GEN_ZERO_GUARD_EN
  logic zero_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      zero_q <= 1'b0;
    end else if (state_q == StSquare) begin
      zero_q <= (rad_c == 64'd0);
    end
  end

  assign zero_guard = zero_q;
`else
  assign zero_guard = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ray_gen_start) state_d = StSquare;
      StSquare: state_d = StSqrt;
      StSqrt:   if (cnt_q == 5'd0) state_d = StDiv;
      StDiv:    if (cnt_q == 5'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ray_gen_done = (state_q == StDone);
  end

  // Datapath
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      vec_q  <= '0;
      mag_q  <= '0;
      sign_q <= '0;
      rad_q  <= '0;
      srem_q <= '0;
      root_q <= '0;
      drem_q <= '0;
      quo_q  <= '0;
      out_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ray_gen_start) vec_q <= {ray_gen_in_z, ray_gen_in_y, ray_gen_in_x};
        end
        StSquare: begin
          mag_q  <= mag_c;
          rad_q  <= rad_c;
          srem_q <= '0;
          root_q <= '0;
          cnt_q  <= 5'd31;
          for (int i = 0; i < 3; i++) sign_q[i] <= vec_q[i][31];
        end
        StSqrt: begin
          rad_q  <= {rad_q[61:0], 2'b00};
          srem_q <= srem_d;
          root_q <= {root_q[30:0], s_ge};
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            cnt_q <= 5'd16;
            quo_q <= '0;
            for (int i = 0; i < 3; i++) drem_q[i] <= {1'b0, mag_q[i][31:1]};
          end
        end
        StDiv: begin
          cnt_q <= cnt_q - 5'd1;
          for (int i = 0; i < 3; i++) begin
            drem_q[i] <= drem_d[i];
            quo_q[i]  <= q_fin[i][15:0];
          end
          if (cnt_q == 5'd0) out_q <= out_d;
        end
        default: ;
      endcase
    end
  end

  assign ray_gen_out_x = out_q[0];
  assign ray_gen_out_y = out_q[1];
  assign ray_gen_out_z = out_q[2];

endmodule

// File: tb/tb_ray_gen_normalizer.sv
// Scoreboard bench for ray_gen_normalizer: expected vectors are queued at start and
// checked (values and 51-cycle latency) when done pulses.
module tb_ray_gen_normalizer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ray_gen_start;
  logic [31:0] ray_gen_in_x, ray_gen_in_y, ray_gen_in_z;
  logic        ray_gen_done;
  logic [31:0] ray_gen_out_x, ray_gen_out_y, ray_gen_out_z;

  ray_gen_normalizer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ray_gen_start (ray_gen_start),
    .ray_gen_in_x  (ray_gen_in_x),
    .ray_gen_in_y  (ray_gen_in_y),
    .ray_gen_in_z  (ray_gen_in_z),
    .ray_gen_done  (ray_gen_done),
    .ray_gen_out_x (ray_gen_out_x),
    .ray_gen_out_y (ray_gen_out_y),
    .ray_gen_out_z (ray_gen_out_z)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    time         t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_sent   = 0;
  int   n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  function automatic logic [31:0] norm_comp(input logic [31:0] c, input logic [63:0] r);
    logic [31:0] m;
    logic [63:0] q;
    m = c[31] ? 32'(-c) : c;
    if (r == 64'd0) begin
`ifdef RAY_GEN_ZERO_GUARD_EN
      return 32'd0;
`else
      return 32'h0001_FFFF;
`endif
    end
    q = (64'(m) << 16) / r;
    return c[31] ? 32'(-q) : q[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z);
    exp_t        e;
    logic [63:0] mx, my, mz, rad, r, t;
    mx  = 64'(x[31] ? 32'(-x) : x);
    my  = 64'(y[31] ? 32'(-y) : y);
    mz  = 64'(z[31] ? 32'(-z) : z);
    rad = mx * mx + my * my + mz * mz;
    r   = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= rad) r = t;
    end
    e.x  = norm_comp(x, r);
    e.y  = norm_comp(y, r);
    e.z  = norm_comp(z, r);
    e.t0 = 0;
    return e;
  endfunction

  task automatic send_exp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input exp_t e);
    exp_t ee;
    ee = e;
    @(negedge clk_in);
    ray_gen_in_x  = x;
    ray_gen_in_y  = y;
    ray_gen_in_z  = z;
    ray_gen_start = 1'b1;
    @(posedge clk_in);
    ee.t0 = $time;
    exp_q.push_back(ee);
    n_sent++;
    @(negedge clk_in);
    ray_gen_start = 1'b0;
    // inputs may change once captured
    ray_gen_in_x  = $urandom();
    ray_gen_in_y  = $urandom();
    ray_gen_in_z  = $urandom();
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    send_exp(x, y, z, model(x, y, z));
  endtask

  function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] z);
    exp_t e;
    e.x  = x;
    e.y  = y;
    e.z  = z;
    e.t0 = 0;
    return e;
  endfunction

  task automatic drain();
    for (int i = 0; i < 120 && exp_q.size() != 0; i++) @(negedge clk_in);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (ray_gen_done) begin
      exp_t e;
      n_done++;
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        check("out_x", ray_gen_out_x, e.x);
        check("out_y", ray_gen_out_y, e.y);
        check("out_z", ray_gen_out_z, e.z);
        check("latency", 32'(($time - e.t0 + 5) / 10), 32'd51);
      end
    end
  end

  initial begin
    int done_before;
    rst_in        = 1'b1;
    ray_gen_start = 1'b0;
    ray_gen_in_x  = '0;
    ray_gen_in_y  = '0;
    ray_gen_in_z  = '0;
    repeat (3) @(negedge clk_in);
    check("rst_done", 32'(ray_gen_done), 32'd0);
    check("rst_out_x", ray_gen_out_x, 32'd0);
    check("rst_out_y", ray_gen_out_y, 32'd0);
    check("rst_out_z", ray_gen_out_z, 32'd0);
    rst_in = 1'b0;

    // Reference vectors with hand-derived results
    send_exp(32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
             mk(32'h0000_93CD, 32'h0000_93CD, 32'h0000_93CD));
    drain();
    repeat (5) @(negedge clk_in);
    check("hold_x", ray_gen_out_x, last_exp.x);
    check("hold_z", ray_gen_out_z, last_exp.z);
    send_exp(32'h0001_0000, 32'h0, 32'h0001_0000, mk(32'd46341, 32'd0, 32'd46341));
    drain();
    send_exp(32'h0001_0000, 32'h1000, 32'h1000, mk(32'd65281, 32'd4080, 32'd4080));
    drain();

    // Start during SQRT is ignored
    send_exp(32'hFFFF_0000, 32'h0, 32'h0, mk(32'hFFFF_0000, 32'd0, 32'd0));
    repeat (10) @(negedge clk_in);
    ray_gen_in_x  = 32'h0000_1234;
    ray_gen_start = 1'b1;
    @(negedge clk_in);
    ray_gen_start = 1'b0;
    drain();
    repeat (60) @(negedge clk_in);
    check("ignored_start", 32'(n_done), 32'(n_sent));

`ifdef RAY_GEN_ZERO_GUARD_EN
    send_exp(32'h0, 32'h0, 32'h0, mk(32'h0, 32'h0, 32'h0));
`else
    send_exp(32'h0, 32'h0, 32'h0, mk(32'h0001_FFFF, 32'h0001_FFFF, 32'h0001_FFFF));
`endif
    drain();

    // Back-to-back: second start on first IDLE cycle after DONE
    send(32'hFFFF_8000, 32'h0000_3000, 32'hFFFE_0000);
    for (int i = 0; i < 80 && !ray_gen_done; i++) @(negedge clk_in);
    send(32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678);
    drain();

    send(32'h0000_0001, 32'h0, 32'h0);
    drain();
    send(32'h0000_0001, 32'h0100_0000, 32'hFFFF_FFFF);
    drain();
    for (int k = 0; k < 6; k++) begin
      send($urandom() & 32'h00FF_FFFF, $urandom(), $urandom() & 32'h8000_FFFF);
      drain();
    end

    // Reset during DIV aborts with no done pulse
    send(32'h0003_0000, 32'h0004_0000, 32'h0);
    repeat (40) @(negedge clk_in);
    done_before = n_done;
    rst_in = 1'b1;
    exp_q.delete();
    @(negedge clk_in);
    check("abort_out_x", ray_gen_out_x, 32'd0);
    check("abort_out_y", ray_gen_out_y, 32'd0);
    rst_in = 1'b0;
    repeat (60) @(negedge clk_in);
    check("abort_no_done", 32'(n_done), 32'(done_before));
    check("abort_out_z", ray_gen_out_z, 32'd0);

    // First start after reset behaves normally
    send(32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ray_gen_normalizer.md
RAY_GEN_NORMALIZER -- requirements
Module: ray_gen

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ray_gen_start, input, 1 bit: request pulse; sampled on the rising edge.
REQ-004 SHALL have ports ray_gen_in_x, ray_gen_in_y, ray_gen_in_z, each input, 32 bits: direction vector, signed two's-complement Q16.16.
REQ-005 SHALL have port ray_gen_done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-006 SHALL have ports ray_gen_out_x, ray_gen_out_y, ray_gen_out_z, each output, 32 bits: unit vector, signed Q16.16.

Function
REQ-007 SHALL compute out_c = trunc(in_c * 2^16 / R) for each component c, where R = floor(sqrt(x^2 + y^2 + z^2)) taken over raw integer values.
- Result: input vector normalized to length 1.0 = 0x0001_0000.
REQ-008 SHALL run in states IDLE -> SQUARE -> SQRT -> DIV -> DONE -> IDLE.
REQ-009 In IDLE, start=1 SHALL capture all three inputs into internal registers and enter SQUARE; the inputs may change afterwards.
REQ-010 SQUARE (1 cycle) SHALL form |x|^2 + |y|^2 + |z|^2 as an unsigned 64-bit Q32.32 radicand (maximum 3*2^62 fits without overflow) and latch the three sign bits.
REQ-011 SQRT (exactly 32 cycles, one root bit per cycle, MSB first) SHALL produce the 32-bit truncated root R (Q16.16).
REQ-012 DIV (exactly 17 cycles) SHALL run three parallel restoring dividers, each producing quotient bits 16..0 of (|in_c| << 16) / R, one bit per cycle, MSB first.
- Quotient never exceeds 0x1_0000.
REQ-013 The sign of each input component SHALL be reapplied to its quotient, negated in two's complement.
- A zero component SHALL give output 0.
REQ-014 DONE SHALL last 1 cycle: outputs updated and done=1 together, then return to IDLE.
- Latency: done SHALL be high in the 51st cycle after the start-sampling edge.
REQ-015 start asserted while not in IDLE SHALL be ignored; there is no queueing.
REQ-016 Outputs SHALL hold their last result until the next DONE.
REQ-017 Back-to-back operation: start SHALL be accepted on the first IDLE cycle after DONE.

Reset
REQ-018 While rst_in=1, state SHALL be IDLE, done=0, all outputs and internal registers 0.
REQ-019 Reset asserted mid-operation SHALL abort the computation with no done pulse.
REQ-020 After reset is released, the first start SHALL behave per REQ-009.

Configuration
REQ-021 Macro RAY_GEN_ZERO_GUARD_EN, when defined, SHALL detect a zero radicand in SQUARE.
- It SHALL force all three outputs to 0 with the normal 51-cycle latency.
REQ-022 Without RAY_GEN_ZERO_GUARD_EN, a zero vector SHALL return the raw divide-by-zero quotient 0x0001_FFFF for each component, with the normal latency.

Verification
REQ-023 Vector (0x10000, 0x10000, 0x10000) -> R = 113511; each output 0x000093CD (37837; >>12 = 9); done after 51 cycles.
REQ-024 Vector (0x10000, 0, 0x10000) -> x = z = 46341 (>>12 = 11), y = 0.
REQ-025 Vector (0x10000, 0x1000, 0x1000) -> R = 65791; x = 65281 (>>12 = 15), y = z = 4080.
REQ-026 Vector (0xFFFF0000, 0, 0) -> x = 0xFFFF0000 (-1.0), y = z = 0.
- Apply start again during SQRT: ignored, exactly one done pulse.
REQ-027 Assert reset during DIV -> no done pulse; outputs 0.
- Vector (0, 0, 0) -> outputs 0 with the macro defined, 0x0001_FFFF without it.
